// File: rtl/sipo_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_frame_rx
//  Description : Serial-in, parallel-out frame receiver. Frames are a start
//                bit (1) followed by DATA_W data bits, MSB first, sampled on
//                bit_en strobes. Each recovered word is held in a one-word
//                output register with a valid/ready handshake so the next
//                frame can shift in while the current word waits.
//                Optional macro SIPO_FRAME_RX_PARITY_EN adds a trailing
//                even-parity bit and drives parity_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_frame_rx #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sdi,
    input  logic              bit_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              overrun,
    output logic              parity_err
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef SIPO_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                overrun_q, overrun_d;

    // Frame assembly result, valid only while frame_done is high
    logic                frame_done;
    logic [DATA_W-1:0]   frame_word;

`ifdef SIPO_FRAME_RX_PARITY_EN
    logic                frame_perr;
    logic                parity_err_q, parity_err_d;
`endif

    // Next-state, shift and bit-counter logic for the frame FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        frame_word = shift_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
        frame_perr = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bit_en && sdi) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (bit_en) begin
                    shift_d = {shift_q[DATA_W-2:0], sdi};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
                        state_d = PAR;
`else
                        state_d    = IDLE;
                        frame_done = 1'b1;
                        frame_word = {shift_q[DATA_W-2:0], sdi};
`endif
                    end
                end
            end
`ifdef SIPO_FRAME_RX_PARITY_EN
            PAR: begin
                if (bit_en) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                    frame_word = shift_q;
                    frame_perr = (^shift_q) ^ sdi;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Holding register: load on completion unless a full, unconsumed word blocks it
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (frame_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = frame_word;
                dout_valid_d = 1'b1;
`ifdef SIPO_FRAME_RX_PARITY_EN
                parity_err_d = frame_perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // State, datapath and holding registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SIPO_FRAME_RX_PARITY_EN
    // Parity flag travels with the held word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire
